// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file.
// Clear-engine states, default sizes, address-width helper.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_st_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback.
// Wipe input lets the soft-clear engine zero one entry per cycle.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              wipe_en,
  input  logic [AW-1:0]     wipe_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    busy_out
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: wipe beats issue, issue beats writeback.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (wipe_en && wipe_addr == AW'(r))
        busy_d[r] = 1'b0;
      else if (set_en && set_addr == AW'(r))
        busy_d[r] = 1'b1;
      else if (clr_en && clr_addr == AW'(r))
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_look
    assign busy_out[i] = busy_q[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with r0 hardwired to zero,
// write bypass, busy scoreboard and a sequential soft clear.
import regfile_pkg::*;

module regfile_mp #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  logic [XLEN-1:0] mem [NREGS];
  clr_st_t         state;
  logic [AW-1:0]   cnt;
  logic            idle;
  logic            wr_ok;
  logic            iss_ok;
  logic [NRD-1:0]  sb_busy;

  assign idle   = (state == ST_IDLE);
  assign wr_ok  = wr_en && idle && (wr_addr != '0);
  assign iss_ok = iss_en && idle && (iss_addr != '0);

  // Soft-clear sequencer; counter walks 1..NREGS-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            cnt      <= AW'(1);
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
      endcase
    end
  end

  // Data array: clear engine owns the write port while active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else if (!idle) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_ok),
    .set_addr  (iss_addr),
    .clr_en    (wr_ok),
    .clr_addr  (wr_addr),
    .wipe_en   (!idle),
    .wipe_addr (cnt),
    .rd_addr   (rd_addr),
    .busy_out  (sb_busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic          iss_hit;
    assign a       = rd_addr[i*AW +: AW];
    assign hit     = (BYPASS != 0) && wr_ok && (wr_addr == a);
    assign iss_hit = iss_ok && (iss_addr == a);
    assign rd_data[i*XLEN +: XLEN] =
      (a == '0) ? '0 :
      hit       ? wr_data :
                  mem[a];
    assign rd_busy[i] =
      (a == '0)           ? 1'b0 :
      (hit && !iss_hit)   ? 1'b0 :
                            sb_busy[i];
  end

endmodule
